// File: rtl/fetch_queue_if.sv
// Handshake and status bundle between a fetch_queue and the logic that feeds
// and drains it; slave = queue side, master = client side.
interface fetch_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OFS_W      = 2,
  parameter int CW         = 7
);
  logic                  flush;
  logic [OFS_W-1:0]      offset;
  logic                  push;
  logic [DATA_WIDTH-1:0] din;
  logic                  pop;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  full;
  logic                  empty;
  logic                  afull;
  logic [CW-1:0]         count;
  logic [CW-1:0]         wp;
  logic [CW-1:0]         rp;
  logic                  ovf;
  logic                  udf;

  modport slave (
    input  flush, offset, push, din, pop,
    output dout, dout_valid, full, empty, afull, count, wp, rp, ovf, udf
  );

  modport master (
    output flush, offset, push, din, pop,
    input  dout, dout_valid, full, empty, afull, count, wp, rp, ovf, udf
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: synchronous FIFO with registered read, flush with
// post-flush push skipping, and optional sticky ovf/udf (FETCH_QUEUE_ERR_FLAGS_EN).
module fetch_queue #(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 32,
  parameter int OFS_W      = 2,
  parameter int AFULL_TH   = DEPTH - 4
) (
  input logic           clk,
  input logic           reset,
  fetch_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]         wp_q, wp_d;
  logic [CW-1:0]         rp_q, rp_d;
  logic [OFS_W-1:0]      skip_q, skip_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;

  logic          full, empty;
  logic [CW-1:0] count;
  logic          push_ok, skip_dec, pop_ok;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[CW-1] != rp_q[CW-1]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign count = wp_q - rp_q;

  assign push_ok  = bus.push && !full && !bus.flush && (skip_q == '0);
  assign skip_dec = bus.push && !full && !bus.flush && (skip_q != '0);
  assign pop_ok   = bus.pop  && !empty && !bus.flush;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wp_d         = wp_q;
    rp_d         = rp_q;
    skip_d       = skip_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    if (bus.flush) begin
      wp_d   = '0;
      rp_d   = '0;
      skip_d = bus.offset;
    end else begin
      if (push_ok)  wp_d   = wp_q + 1'b1;
      if (skip_dec) skip_d = skip_q - 1'b1;
      if (pop_ok) begin
        rp_d         = rp_q + 1'b1;
        dout_d       = mem[rp_q[AW-1:0]];
        dout_valid_d = 1'b1;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q         <= '0;
      rp_q         <= '0;
      skip_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      skip_q       <= skip_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // NOTE: the storage array has no reset; stale entries are never visible
  // because the pointers are reset, and a reset-free array maps onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wp_q[AW-1:0]] <= bus.din;
  end

`ifdef FETCH_QUEUE_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (bus.flush) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (bus.push && full)  ovf_d = 1'b1;
      if (bus.pop  && empty) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign bus.ovf = ovf_q;
  assign bus.udf = udf_q;
`else
  assign bus.ovf = 1'b0;
  assign bus.udf = 1'b0;
`endif

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.afull      = (count >= AFULL_C);
  assign bus.count      = count;
  assign bus.wp         = wp_q;
  assign bus.rp         = rp_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue at DEPTH=8; ovf/udf expectations follow
// FETCH_QUEUE_ERR_FLAGS_EN.
module tb_fetch_queue;
  localparam int DEPTH = 8;
  localparam int DW    = 32;
  localparam int OW    = 2;
  localparam int CW    = 4;
`ifdef FETCH_QUEUE_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fetch_queue_if #(.DATA_WIDTH(DW), .OFS_W(OW), .CW(CW)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .OFS_W(OW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic [OW-1:0] ofs, input logic ps,
                       input logic [DW-1:0] d, input logic pp);
    bus.flush  = f;
    bus.offset = ofs;
    bus.push   = ps;
    bus.din    = d;
    bus.pop    = pp;
  endtask

  task automatic do_flush(input logic [OW-1:0] ofs);
    drive(1'b1, ofs, 1'b0, '0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    tick(); tick();
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rst_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.full !== 1'b0 || bus.afull !== 1'b0) begin errors++; $display("FAIL rst_full_afull got=%b%b exp=00", bus.full, bus.afull); end
    checks++; if (bus.dout !== 32'h0 || bus.dout_valid !== 1'b0) begin errors++; $display("FAIL rst_dout got=%h/%b exp=0/0", bus.dout, bus.dout_valid); end
    checks++; if (bus.wp !== 4'd0 || bus.rp !== 4'd0) begin errors++; $display("FAIL rst_ptrs got=%0d/%0d exp=0/0", bus.wp, bus.rp); end
    checks++; if (bus.ovf !== 1'b0 || bus.udf !== 1'b0) begin errors++; $display("FAIL rst_err got=%b%b exp=00", bus.ovf, bus.udf); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '0, 1'b1, DW'(32'h10 + i), 1'b0);
      tick();
      checks++; if (bus.count !== CW'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, bus.count, i + 1); end
      checks++; if (bus.afull !== (i + 1 >= 4)) begin errors++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, bus.afull, (i + 1 >= 4)); end
      checks++; if (bus.full !== (i == 7)) begin errors++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, bus.full, (i == 7)); end
    end
    drive(1'b0, '0, 1'b1, 32'h99, 1'b0);
    tick();
    checks++; if (bus.count !== 4'd8 || bus.wp !== 4'h8) begin errors++; $display("FAIL drop_9th got=%0d/%0d exp=8/8", bus.count, bus.wp); end
    checks++; if (bus.ovf !== ERR_EN) begin errors++; $display("FAIL drop_ovf got=%b exp=%b", bus.ovf, ERR_EN); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '0, 1'b0, '0, 1'b1);
      tick();
      checks++; if (bus.dout_valid !== 1'b1 || bus.dout !== DW'(32'h10 + i)) begin errors++; $display("FAIL drain_data[%0d] got=%h/%b exp=%h/1", i, bus.dout, bus.dout_valid, 32'h10 + i); end
      checks++; if (bus.count !== CW'(7 - i)) begin errors++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, bus.count, 7 - i); end
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    tick();
    checks++; if (bus.empty !== 1'b1 || bus.dout_valid !== 1'b0) begin errors++; $display("FAIL drain_idle got=%b/%b exp=1/0", bus.empty, bus.dout_valid); end
    checks++; if (bus.dout !== 32'h17) begin errors++; $display("FAIL dout_hold got=%h exp=17", bus.dout); end
    checks++; if (bus.ovf !== ERR_EN) begin errors++; $display("FAIL ovf_sticky got=%b exp=%b", bus.ovf, ERR_EN); end
    do_flush('0);
    checks++; if (bus.ovf !== 1'b0 || bus.wp !== 4'd0) begin errors++; $display("FAIL ovf_flush got=%b/%0d exp=0/0", bus.ovf, bus.wp); end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) begin
        drive(1'b0, '0, 1'b1, DW'(32'h30 + r * 8 + i), 1'b0);
        tick();
        checks++; if (bus.count !== CW'(i + 1)) begin errors++; $display("FAIL wrap_fill[%0d.%0d] got=%0d exp=%0d", r, i, bus.count, i + 1); end
      end
      for (int i = 0; i < 6; i++) begin
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        tick();
        checks++; if (bus.dout !== DW'(32'h30 + r * 8 + i) || bus.count !== CW'(5 - i)) begin errors++; $display("FAIL wrap_pop[%0d.%0d] got=%h/%0d exp=%h/%0d", r, i, bus.dout, bus.count, 32'h30 + r * 8 + i, 5 - i); end
      end
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    tick();
    checks++; if (bus.wp !== 4'd2 || bus.rp !== 4'd2 || bus.empty !== 1'b1) begin errors++; $display("FAIL wrap_ptrs got=%0d/%0d/%b exp=2/2/1", bus.wp, bus.rp, bus.empty); end
  endtask

  task automatic test_flush_offset();
    drive(1'b0, '0, 1'b1, 32'hEE, 1'b0);
    tick(); tick();
    drive(1'b1, 2'd3, 1'b1, 32'hEF, 1'b1);
    tick();
    checks++; if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.dout_valid !== 1'b0) begin errors++; $display("FAIL flush_state got=%0d/%b/%b exp=0/1/0", bus.count, bus.empty, bus.dout_valid); end
    checks++; if (bus.wp !== 4'd0 || bus.rp !== 4'd0) begin errors++; $display("FAIL flush_ptrs got=%0d/%0d exp=0/0", bus.wp, bus.rp); end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, '0, 1'b1, DW'(32'hA + i), 1'b0);
      tick();
      checks++; if (bus.count !== CW'(i < 3 ? 0 : i - 2)) begin errors++; $display("FAIL skip_count[%0d] got=%0d exp=%0d", i, bus.count, i < 3 ? 0 : i - 2); end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b0, '0, 1'b1);
      tick();
      checks++; if (bus.dout !== DW'(32'hD + i) || bus.dout_valid !== 1'b1) begin errors++; $display("FAIL skip_data[%0d] got=%h/%b exp=%h/1", i, bus.dout, bus.dout_valid, 32'hD + i); end
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_full_push_pop();
    do_flush('0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '0, 1'b1, DW'(32'h20 + i), 1'b0);
      tick();
    end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fpp_full got=%b exp=1", bus.full); end
    drive(1'b0, '0, 1'b1, 32'h77, 1'b1);
    tick();
    checks++; if (bus.count !== 4'd7 || bus.dout !== 32'h20 || bus.dout_valid !== 1'b1) begin errors++; $display("FAIL fpp_step got=%0d/%h/%b exp=7/20/1", bus.count, bus.dout, bus.dout_valid); end
    checks++; if (bus.ovf !== ERR_EN) begin errors++; $display("FAIL fpp_ovf got=%b exp=%b", bus.ovf, ERR_EN); end
    for (int i = 1; i < 8; i++) begin
      drive(1'b0, '0, 1'b0, '0, 1'b1);
      tick();
      checks++; if (bus.dout !== DW'(32'h20 + i)) begin errors++; $display("FAIL fpp_drain[%0d] got=%h exp=%h", i, bus.dout, 32'h20 + i); end
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    tick();
    checks++; if (bus.empty !== 1'b1 || bus.ovf !== ERR_EN) begin errors++; $display("FAIL fpp_end got=%b/%b exp=1/%b", bus.empty, bus.ovf, ERR_EN); end
    do_flush('0);
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL fpp_flush_ovf got=%b exp=0", bus.ovf); end
  endtask

  task automatic test_empty_pop_push();
    drive(1'b0, '0, 1'b1, 32'h55, 1'b1);
    tick();
    checks++; if (bus.dout_valid !== 1'b0 || bus.count !== 4'd1) begin errors++; $display("FAIL epp_step got=%b/%0d exp=0/1", bus.dout_valid, bus.count); end
    checks++; if (bus.udf !== ERR_EN) begin errors++; $display("FAIL epp_udf got=%b exp=%b", bus.udf, ERR_EN); end
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    tick();
    checks++; if (bus.dout !== 32'h55 || bus.dout_valid !== 1'b1 || bus.empty !== 1'b1) begin errors++; $display("FAIL epp_pop got=%h/%b/%b exp=55/1/1", bus.dout, bus.dout_valid, bus.empty); end
    do_flush('0);
    checks++; if (bus.udf !== 1'b0) begin errors++; $display("FAIL epp_flush_udf got=%b exp=0", bus.udf); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, '0, 1'b1, DW'(32'h40 + i), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    tick();
    checks++; if (bus.count !== 4'd5 || bus.dout_valid !== 1'b1) begin errors++; $display("FAIL ar_pre got=%0d/%b exp=5/1", bus.count, bus.dout_valid); end
    drive(1'b0, '0, 1'b1, 32'h66, 1'b1);
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.dout_valid !== 1'b0) begin errors++; $display("FAIL ar_async got=%0d/%b/%b exp=0/1/0", bus.count, bus.empty, bus.dout_valid); end
    checks++; if (bus.wp !== 4'd0 || bus.dout !== 32'h0) begin errors++; $display("FAIL ar_regs got=%0d/%h exp=0/0", bus.wp, bus.dout); end
    tick();
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL ar_held got=%0d exp=0", bus.count); end
    #2 reset = 1'b1;
    tick();
    checks++; if (bus.count !== 4'd1 || bus.dout_valid !== 1'b0) begin errors++; $display("FAIL ar_first got=%0d/%b exp=1/0", bus.count, bus.dout_valid); end
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    tick();
    checks++; if (bus.dout !== 32'h66 || bus.dout_valid !== 1'b1) begin errors++; $display("FAIL ar_data got=%h/%b exp=66/1", bus.dout, bus.dout_valid); end
    drive(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_flush_offset();
    test_full_push_pop();
    test_empty_pop_push();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
